sram_port_initiator: RTL

Initiator side of the single-port SRAM wrapper interface (CE/WE/WEM/A/D/Q, active-high CE and WE, synchronous read with fixed latency). Converts a valid/ready request stream into registered memory port strobes and returns read data on a valid/ready response stream. Read credits are reserved at issue, so returning data is never dropped even though the memory cannot be stalled. One instance per memory port; a dual-port macro uses two instances.

---
 rtl/sram_if_pkg.sv | 22 ++
 rtl/sram_rsp_fifo.sv | 67 ++++++
 rtl/sram_port_initiator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sram_if_pkg.sv
// rtl/sram_if_pkg.sv - shared constants and helpers for the SRAM port initiator
// Provides default address/data widths and a pointer-width helper used to size
// FIFO pointers and occupancy counters.

package sram_if_pkg;

    localparam int SRAM_ADDR_W = 6;
    localparam int SRAM_DATA_W = 4;

    // Bits needed to index 0..depth-1, never less than 1.
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - synchronous first-word-fall-through response FIFO
// Ports: i_clk/i_rst clock and async active-high reset; i_push/i_data write side;
// i_pop read side; o_data head entry; o_full/o_empty/o_count occupancy status.
// Any depth >= 1 is supported; pointers wrap modulo DEPTH.

module sram_rsp_fifo
    import sram_if_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int DEPTH  = 3,
    localparam int CNT_W = ptr_width(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Push while full is fine when a pop is consumed in the same cycle:
            // the slot being overwritten is the one leaving.
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_port_initiator.sv
// rtl/sram_port_initiator.sv - valid/ready initiator for a single-port SRAM wrapper
// Ports: CLK/RST clock and async active-high reset; req_* request stream
// (we/addr/wdata/wem); rsp_* read response stream; CE/WE/WEM/A/D registered
// memory strobes; Q memory read data, valid RD_LAT cycles after the CE cycle.
// Read credits are reserved at accept so returning Q always has FIFO room.

module sram_port_initiator
    import sram_if_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wem,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              CE,
    output logic              WE,
    output logic [DATA_W-1:0] WEM,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    localparam int CNT_W = ptr_width(RSP_DEPTH + 1);

    logic              r_ce;
    logic              r_we;
    logic [DATA_W-1:0] r_wem;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic [CNT_W-1:0]  r_in_use;

    logic              w_req_fire;
    logic              w_rd_fire;
    logic              w_pop;
    logic              w_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_pop = rsp_valid & rsp_ready;

    // A credit released by this cycle's pop is immediately reusable, which is
    // what lets RSP_DEPTH = RD_LAT+2 sustain one read per cycle.
    assign req_ready  = req_we | (r_in_use < CNT_W'(RSP_DEPTH)) | w_pop;
    assign w_req_fire = req_valid & req_ready;
    assign w_rd_fire  = w_req_fire & ~req_we;
    assign w_push     = r_rd_pipe[RD_LAT-1];

    // Address/data/mask hold their last value when idle to avoid toggling.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ce  <= 1'b0;
            r_we  <= 1'b0;
            r_wem <= '0;
            r_a   <= '0;
            r_d   <= '0;
        end else begin
            r_ce <= w_req_fire;
            r_we <= w_req_fire & req_we;
            if (w_req_fire) begin
                r_a   <= req_addr;
                r_d   <= req_we ? req_wdata : '0;
                r_wem <= req_we ? req_wem : '0;
            end
        end
    end

    // Tail bit marks the cycle in which Q carries valid read data.
    if (RD_LAT == 1) begin : g_pipe_one
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_rd_pipe <= '0;
            end else begin
                r_rd_pipe <= r_ce & ~r_we;
            end
        end
    end else begin : g_pipe_many
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_rd_pipe <= '0;
            end else begin
                r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], r_ce & ~r_we};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_in_use <= '0;
        end else begin
            case ({w_rd_fire, w_pop})
                2'b10:   r_in_use <= r_in_use + 1'b1;
                2'b01:   r_in_use <= r_in_use - 1'b1;
                default: r_in_use <= r_in_use;
            endcase
        end
    end

    sram_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_data  (Q),
        .i_pop   (w_pop),
        .o_data  (rsp_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign rsp_valid = ~w_fifo_empty;

    assign CE  = r_ce;
    assign WE  = r_we;
    assign WEM = r_wem;
    assign A   = r_a;
    assign D   = r_d;

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_push && w_fifo_full && !w_pop));

    a_credit_covers_fifo: assert property (@(posedge CLK) disable iff (RST)
        r_in_use >= w_fifo_count);

endmodule
